// File: rtl/ap_host_sequencer_if.sv
// ap_host_sequencer_if
//   Bundles the operand stream, the result stream and the AP_s control/data
//   bus that the host sequencer drives.
//   master : sequencer view (consumes operands, produces results, drives AP)
//   slave  : environment view (operand source, result sink, AP_s array)
//   Signals:
//     in_valid/in_ready/in_data            operand stream
//     out_valid/out_ready/out_data/out_last result stream
//     ap_*                                  AP_s port set
interface ap_host_sequencer_if #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned ADDR_W    = 9
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] in_data;

    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_data;
    logic                 out_last;

    logic [ADDR_W-1:0]    ap_addr;
    logic [WORD_SIZE-1:0] ap_data;
    logic                 ap_rst;
    logic                 ap_mode;
    logic                 ap_write_en;
    logic                 ap_read_en;
    logic                 ap_sel_col;
    logic                 ap_sel_internal_col;
    logic [2:0]           ap_cmd;
    logic [WORD_SIZE-1:0] ap_data_out;
    logic                 ap_state_irq;

    modport master (
        input  in_valid, in_data, out_ready, ap_data_out, ap_state_irq,
        output in_ready, out_valid, out_data, out_last,
        output ap_addr, ap_data, ap_rst, ap_mode, ap_write_en, ap_read_en,
        output ap_sel_col, ap_sel_internal_col, ap_cmd
    );

    modport slave (
        output in_valid, in_data, out_ready, ap_data_out, ap_state_irq,
        input  in_ready, out_valid, out_data, out_last,
        input  ap_addr, ap_data, ap_rst, ap_mode, ap_write_en, ap_read_en,
        input  ap_sel_col, ap_sel_internal_col, ap_cmd
    );
endinterface

// File: rtl/ap_host_sequencer.sv
// ap_host_sequencer
//   Host-side initiator for AP_s. On start it clears both internal banks,
//   writes CELL_QUANT operand-A words (sel_col=0) then CELL_QUANT operand-B
//   words (sel_col=1), launches one compute, waits for ap_state_irq and then
//   reads the result column back as a valid/ready stream.
//   Ports:
//     CLK100MHZ   clock, rising edge
//     rst         synchronous active-high reset
//     start       one-cycle start pulse, accepted only when idle
//     cmd_in      AP opcode latched on an accepted start
//     busy        high whenever not idle
//     done        one-cycle pulse after the last result transfer
//     err         sticky compute timeout flag
//     bus         operand/result streams and AP_s bus (master modport)
//   All outputs are registered; each next value is decided on the edge that
//   enters the state it belongs to.
module ap_host_sequencer #(
    parameter int unsigned WORD_SIZE   = 8,
    parameter int unsigned CELL_QUANT  = 512,
    parameter int unsigned ADDR_W      = $clog2(CELL_QUANT),
    parameter int unsigned CLR_CYCLES  = 4,
    parameter int unsigned READ_LAT    = 2,
    parameter bit          RES_SEL_COL = 1'b0,
    parameter bit          RES_SEL_INT = 1'b1,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic       CLK100MHZ,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] cmd_in,
    output logic       busy,
    output logic       done,
    output logic       err,
    ap_host_sequencer_if.master bus
);

    localparam int unsigned CntMax0 = (CLR_CYCLES > READ_LAT) ? CLR_CYCLES : READ_LAT;
    localparam int unsigned CntMax  = (CntMax0 > TIMEOUT) ? CntMax0 : TIMEOUT;
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    localparam logic [CntW-1:0]   ClrLast  = CntW'(CLR_CYCLES - 1);
    localparam logic [CntW-1:0]   ReadLast = CntW'(READ_LAT - 1);
    localparam logic [CntW-1:0]   ToLast   = CntW'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] RowLast  = ADDR_W'(CELL_QUANT - 1);

    typedef enum logic [3:0] {
        StIdle, StClr0, StClr1, StLoadA, StLoadB, StCompute,
        StWaitIrq, StReadReq, StReadWait, StOut, StErr
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]    row_q, row_d;
    logic [2:0]           cmd_q, cmd_d;

    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [WORD_SIZE-1:0] out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [ADDR_W-1:0]    ap_addr_q, ap_addr_d;
    logic [WORD_SIZE-1:0] ap_data_q, ap_data_d;
    logic                 ap_rst_q, ap_rst_d;
    logic                 ap_mode_q, ap_mode_d;
    logic                 ap_write_en_q, ap_write_en_d;
    logic                 ap_read_en_q, ap_read_en_d;
    logic                 ap_sel_col_q, ap_sel_col_d;
    logic                 ap_sel_int_q, ap_sel_int_d;
    logic [2:0]           ap_cmd_q, ap_cmd_d;

    logic in_xfer, out_xfer;

    // in_ready_q is only ever high inside the load states.
    assign in_xfer  = bus.in_valid & in_ready_q;
    assign out_xfer = out_valid_q & bus.out_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        row_d         = row_q;
        cmd_d         = cmd_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        done_d        = 1'b0;
        err_d         = err_q;
        ap_addr_d     = ap_addr_q;
        ap_data_d     = ap_data_q;
        ap_rst_d      = ap_rst_q;
        ap_mode_d     = ap_mode_q;
        ap_write_en_d = 1'b0;
        ap_read_en_d  = 1'b0;
        ap_sel_col_d  = ap_sel_col_q;
        ap_sel_int_d  = ap_sel_int_q;
        ap_cmd_d      = ap_cmd_q;

        unique case (state_q)
            StIdle: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                if (start) begin
                    state_d      = StClr0;
                    cmd_d        = cmd_in;
                    err_d        = 1'b0;
                    cnt_d        = '0;
                    row_d        = '0;
                    ap_rst_d     = 1'b1;
                    ap_sel_int_d = 1'b0;
                end
            end
            StClr0: begin
                if (cnt_q == ClrLast) begin
                    state_d      = StClr1;
                    cnt_d        = '0;
                    ap_sel_int_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StClr1: begin
                if (cnt_q == ClrLast) begin
                    state_d      = StLoadA;
                    cnt_d        = '0;
                    row_d        = '0;
                    ap_rst_d     = 1'b0;
                    ap_mode_d    = 1'b0;
                    ap_sel_col_d = 1'b0;
                    ap_sel_int_d = 1'b0;
                    in_ready_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLoadA, StLoadB: begin
                if (in_xfer) begin
                    ap_write_en_d = 1'b1;
                    ap_addr_d     = row_q;
                    ap_data_d     = bus.in_data;
                    // Column follows the state the word was accepted in, so the
                    // last A word is not written into column B.
                    ap_sel_col_d  = (state_q == StLoadB);
                    if (row_q == RowLast) begin
                        row_d = '0;
                        if (state_q == StLoadA) begin
                            state_d = StLoadB;
                        end else begin
                            state_d    = StCompute;
                            in_ready_d = 1'b0;
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            StCompute: begin
                ap_cmd_d  = cmd_q;
                ap_mode_d = 1'b1;
                cnt_d     = '0;
                state_d   = StWaitIrq;
            end
            StWaitIrq: begin
                if (bus.ap_state_irq) begin
                    ap_mode_d    = 1'b0;
                    row_d        = '0;
                    state_d      = StReadReq;
                    ap_read_en_d = 1'b1;
                    ap_addr_d    = '0;
                    ap_sel_col_d = RES_SEL_COL;
                    ap_sel_int_d = RES_SEL_INT;
                end else if (cnt_q == ToLast) begin
                    ap_mode_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = StErr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StReadReq: begin
                cnt_d   = '0;
                state_d = StReadWait;
            end
            StReadWait: begin
                // cnt_q == READ_LAT-1 is exactly READ_LAT cycles after the
                // read_en cycle.
                if (cnt_q == ReadLast) begin
                    out_data_d  = bus.ap_data_out;
                    out_valid_d = 1'b1;
                    out_last_d  = (row_q == RowLast);
                    state_d     = StOut;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StOut: begin
                if (out_xfer) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (row_q == RowLast) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        row_d        = row_q + 1'b1;
                        ap_read_en_d = 1'b1;
                        ap_addr_d    = row_q + 1'b1;
                        state_d      = StReadReq;
                    end
                end
            end
            StErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            row_q         <= '0;
            cmd_q         <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            ap_addr_q     <= '0;
            ap_data_q     <= '0;
            ap_rst_q      <= 1'b0;
            ap_mode_q     <= 1'b0;
            ap_write_en_q <= 1'b0;
            ap_read_en_q  <= 1'b0;
            ap_sel_col_q  <= 1'b0;
            ap_sel_int_q  <= 1'b0;
            ap_cmd_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            row_q         <= row_d;
            cmd_q         <= cmd_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            ap_addr_q     <= ap_addr_d;
            ap_data_q     <= ap_data_d;
            ap_rst_q      <= ap_rst_d;
            ap_mode_q     <= ap_mode_d;
            ap_write_en_q <= ap_write_en_d;
            ap_read_en_q  <= ap_read_en_d;
            ap_sel_col_q  <= ap_sel_col_d;
            ap_sel_int_q  <= ap_sel_int_d;
            ap_cmd_q      <= ap_cmd_d;
        end
    end

    assign busy                    = busy_q;
    assign done                    = done_q;
    assign err                     = err_q;
    assign bus.in_ready            = in_ready_q;
    assign bus.out_valid           = out_valid_q;
    assign bus.out_data            = out_data_q;
    assign bus.out_last            = out_last_q;
    assign bus.ap_addr             = ap_addr_q;
    assign bus.ap_data             = ap_data_q;
    assign bus.ap_rst              = ap_rst_q;
    assign bus.ap_mode             = ap_mode_q;
    assign bus.ap_write_en         = ap_write_en_q;
    assign bus.ap_read_en          = ap_read_en_q;
    assign bus.ap_sel_col          = ap_sel_col_q;
    assign bus.ap_sel_internal_col = ap_sel_int_q;
    assign bus.ap_cmd              = ap_cmd_q;

endmodule

// File: tb/tb_ap_host_sequencer.sv
// Bench for ap_host_sequencer with CELL_QUANT=8, READ_LAT=2, CLR_CYCLES=4,
// TIMEOUT=100. A small AP model stores written words per column and returns
// A|B for a read, READ_LAT cycles later; it raises ap_state_irq 20 cycles
// after ap_mode rises. Expected writes and results are queued when stimulus
// is issued and popped by negedge monitors.
module tb_ap_host_sequencer;
    localparam int unsigned WS = 8;
    localparam int unsigned CQ = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned TO = 100;
    localparam int unsigned IRQ_DLY = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    cmd_in;
    logic          busy, done, err;

    ap_host_sequencer_if #(.WORD_SIZE(WS), .ADDR_W(AW)) bus ();

    ap_host_sequencer #(
        .WORD_SIZE  (WS),
        .CELL_QUANT (CQ),
        .ADDR_W     (AW),
        .CLR_CYCLES (4),
        .READ_LAT   (2),
        .RES_SEL_COL(1'b0),
        .RES_SEL_INT(1'b1),
        .TIMEOUT    (TO)
    ) dut (
        .CLK100MHZ(clk),
        .rst      (rst),
        .start    (start),
        .cmd_in   (cmd_in),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- AP model ----------------
    logic [WS-1:0] bank_a [CQ];
    logic [WS-1:0] bank_b [CQ];
    logic          rd_v1 = 1'b0;
    logic [AW-1:0] rd_a1;
    int            mode_cnt = 0;
    bit            irq_en = 1'b1;

    initial begin
        bus.ap_data_out  = 8'h5A;
        bus.ap_state_irq = 1'b0;
        for (int i = 0; i < CQ; i++) begin
            bank_a[i] = '0;
            bank_b[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (bus.ap_rst) begin
            for (int i = 0; i < CQ; i++) begin
                if (!bus.ap_sel_internal_col) bank_a[i] <= '0;
                else                          bank_b[i] <= '0;
            end
        end else if (bus.ap_write_en) begin
            if (!bus.ap_sel_col) bank_a[bus.ap_addr] <= bus.ap_data;
            else                 bank_b[bus.ap_addr] <= bus.ap_data;
        end
        rd_v1 <= bus.ap_read_en;
        rd_a1 <= bus.ap_addr;
        // Data is valid only in the single cycle READ_LAT after read_en.
        if (rd_v1) bus.ap_data_out <= bank_a[rd_a1] | bank_b[rd_a1];
        else       bus.ap_data_out <= 8'h5A;
        if (bus.ap_mode) begin
            mode_cnt <= mode_cnt + 1;
            if (irq_en && mode_cnt == IRQ_DLY - 1) bus.ap_state_irq <= 1'b1;
        end else begin
            mode_cnt         <= 0;
            bus.ap_state_irq <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [11:0] wr_q [$];   // {sel_col, addr, data}
    logic [8:0]  out_q [$];  // {last, data}
    logic [2:0]  exp_cmd;
    bit          rand_ready = 1'b0;
    int          done_cnt = 0;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        #1 bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [AW-1:0] rd_idx = '0;
    logic          mode_prev = 1'b0;
    logic          hold_prev = 1'b0;
    logic [WS-1:0] hold_data = '0;
    logic          exp_done = 1'b0;
    logic [11:0]   we;
    logic [8:0]    oe;

    always @(negedge clk) begin
        if (rst) begin
            rd_idx    = '0;
            mode_prev = 1'b0;
            hold_prev = 1'b0;
            exp_done  = 1'b0;
        end else begin
            if (bus.ap_write_en) begin
                wr_cnt++;
                if (wr_q.size() == 0) chk("write_unexpected", 1, 0);
                else begin
                    we = wr_q.pop_front();
                    chk("write", {bus.ap_sel_col, bus.ap_addr, bus.ap_data}, we);
                end
            end
            if (bus.ap_read_en) begin
                chk("read_req", {bus.ap_sel_col, bus.ap_sel_internal_col, bus.ap_addr},
                    {1'b0, 1'b1, rd_idx});
                rd_idx = rd_idx + 1'b1;
            end
            if (bus.ap_mode && !mode_prev) chk("ap_cmd", bus.ap_cmd, exp_cmd);
            mode_prev = bus.ap_mode;

            if (done || exp_done) chk("done", done, exp_done);
            if (done) done_cnt++;
            exp_done = 1'b0;
            if (bus.out_valid) begin
                if (hold_prev) chk("out_stable", bus.out_data, hold_data);
                if (bus.out_ready) begin
                    if (out_q.size() == 0) chk("out_unexpected", 1, 0);
                    else begin
                        oe = out_q.pop_front();
                        chk("out_word", {bus.ap_mode, bus.out_last, bus.out_data}, {1'b0, oe});
                    end
                    exp_done = bus.out_last;
                end
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
        end
    end

    // ---------------- stimulus ----------------
    logic [WS-1:0] cur_a [CQ];
    logic [WS-1:0] cur_b [CQ];
    int            feed_idx;

    task automatic check_all_zero(input string name);
        chk(name, {busy, done, err, bus.in_ready, bus.out_valid, bus.out_last,
                   bus.ap_rst, bus.ap_mode, bus.ap_write_en, bus.ap_read_en,
                   bus.ap_sel_col, bus.ap_sel_internal_col, bus.ap_addr, bus.ap_data,
                   bus.ap_cmd, bus.out_data}, 64'd0);
    endtask

    task automatic do_start(input logic [2:0] cmd);
        @(negedge clk);
        start   = 1'b1;
        cmd_in  = cmd;
        exp_cmd = cmd;
        feed_idx = 0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("err_cleared", err, 0);
        for (int i = 0; i < 4; i++) begin
            chk("clr0", {bus.ap_rst, bus.ap_sel_internal_col, bus.in_ready}, 3'b100);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            chk("clr1", {bus.ap_rst, bus.ap_sel_internal_col, bus.in_ready}, 3'b110);
            @(negedge clk);
        end
        chk("clr_exit", {bus.ap_rst, bus.in_ready}, 2'b01);
    endtask

    task automatic feed(input int n, input bit gaps);
        int sent = 0;
        int budget = 500;
        logic [WS-1:0] d;
        while (sent < n && budget > 0) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hEE;
            end else if (bus.in_ready) begin
                d = (feed_idx < CQ) ? cur_a[feed_idx] : cur_b[feed_idx - CQ];
                bus.in_valid = 1'b1;
                bus.in_data  = d;
                wr_q.push_back({feed_idx >= CQ, AW'(feed_idx % CQ), d});
                feed_idx++;
                sent++;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            budget--;
        end
        bus.in_valid = 1'b0;
        if (sent < n) chk("feed_timeout", sent, n);
    endtask

    task automatic push_results();
        for (int r = 0; r < CQ; r++) out_q.push_back({r == CQ - 1, cur_a[r] | cur_b[r]});
    endtask

    task automatic drain();
        int target = done_cnt + 1;
        int budget = 2000;
        while (done_cnt < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (done_cnt < target) chk("drain_timeout", done_cnt, target);
        @(negedge clk);
        chk("results_all_seen", out_q.size(), 0);
        chk("idle_after_done", {busy, bus.out_valid}, 2'b00);
    endtask

    task automatic full_load(input bit gaps);
        feed(16, gaps);
        chk("in_ready_low_after_load", bus.in_ready, 0);
        @(negedge clk);
        chk("writes_all_seen", wr_q.size(), 0);
    endtask

    initial begin
        int n;
        int budget;
        rst          = 1'b1;
        start        = 1'b0;
        cmd_in       = 3'b000;
        exp_cmd      = 3'b000;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 1'b0;

        // Run 1: A=1..8, B=F0..F7, valid held high, ready always high.
        for (int i = 0; i < CQ; i++) begin
            cur_a[i] = WS'(i + 1);
            cur_b[i] = WS'(8'hF0 + i);
        end
        rand_ready = 1'b0;
        do_start(3'b000);
        full_load(1'b0);
        chk("writes_run1", wr_cnt, 16);
        push_results();
        drain();

        // Run 2: input gaps and random out_ready.
        cur_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        cur_b = '{8'h0F, 8'h80, 8'h01, 8'h10, 8'hAA, 8'h00, 8'h08, 8'h70};
        rand_ready = 1'b1;
        do_start(3'b101);
        full_load(1'b1);
        push_results();
        drain();

        // Run 3: no irq -> timeout after TO cycles in WAIT_IRQ.
        irq_en = 1'b0;
        do_start(3'b010);
        full_load(1'b0);
        budget = 200;
        while (!bus.ap_mode && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n = 0;
        while (!err && n < 300) begin
            if (bus.ap_mode) n++;
            @(negedge clk);
        end
        chk("timeout_cycles", n, TO);
        chk("err_set", {err, bus.ap_mode, bus.out_valid}, 3'b100);
        @(negedge clk);
        chk("idle_after_err", {busy, err, done}, 3'b010);
        repeat (5) @(negedge clk);
        chk("err_sticky", err, 1);

        // Run 4: next start clears err; reset after the 5th A write.
        irq_en = 1'b1;
        do_start(3'b011);
        feed(5, 1'b0);
        @(negedge clk);
        chk("writes_before_rst", wr_q.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("outputs_after_midload_rst");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle_after_rst");

        cur_a = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        cur_b = '{8'hC0, 8'h30, 8'h0C, 8'h03, 8'h00, 8'hFF, 8'h5A, 8'h81};
        do_start(3'b011);
        full_load(1'b1);
        push_results();
        drain();
        chk("done_pulses", done_cnt, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
